fclass_cvt_unit: RTL and testbench
==================================

FCLASS_CVT_UNIT -- requirements
Module: fclass_cvt_unit

Interface
REQ-001 The block SHALL have one parameter: FLEN, default 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operation request, sampled at each rising clk edge.
REQ-005 The block SHALL have port op, input, 2 bits: 0 = FCLASS.S, 1 = FCVT.S.W, 2 = FCVT.S.WU, 3 = reserved.
REQ-006 The block SHALL have port rs1, input, 32 bits: float operand (FCLASS) or integer operand (converts).
REQ-007 The block SHALL have port rs2, input, 32 bits: unused; kept for FPU port uniformity and ignored.
REQ-008 The block SHALL have port out, output, 32 bits: registered result.
REQ-009 The block SHALL have port out_valid, output, 1 bit: high for the cycle in which out holds a new result.

Function
REQ-010 The block SHALL have a latency of exactly 1 cycle: an edge sampling in_valid=1 loads out, and out_valid=1 after that edge.
REQ-011 The block SHALL accept a new request every cycle, with no stall and no backpressure.
REQ-012 When in_valid=0, out SHALL hold its previous value and out_valid SHALL go to 0.
REQ-013 For FCLASS.S, out[31:10] SHALL be 0 and exactly one bit of out[9:0] SHALL be set, per RISC-V:
- bit 0: -inf; bit 1: negative normal; bit 2: negative subnormal; bit 3: -0
- bit 4: +0; bit 5: positive subnormal; bit 6: positive normal; bit 7: +inf
- bit 8: signaling NaN (exp=FF, frac!=0, frac[22]=0)
- bit 9: quiet NaN (exp=FF, frac[22]=1)
- The sign of a NaN is ignored.
REQ-014 For FCVT.S.W, rs1 SHALL be treated as two's-complement int32 and converted to IEEE-754 binary32 with round-to-nearest-even.
REQ-015 For FCVT.S.WU, rs1 SHALL be treated as unsigned uint32 and converted with round-to-nearest-even.
REQ-016 Conversion datapath:
- Take the magnitude (the -2^31 magnitude is 2^31 and SHALL NOT overflow).
- Leading-zero count gives the exponent: exp = 127 + msb_index.
- Keep a 24-bit significand with guard and sticky bits.
- Round up when guard=1 and (sticky=1 or lsb=1).
- If rounding carries out of the significand, renormalise and increment the exponent.
REQ-017 An integer input of 0 SHALL produce +0 (0x00000000) for both conversions; a -0 result is never produced.
REQ-018 Conversion results SHALL never be subnormal, infinite or NaN; the largest result is 0x4F800000.
REQ-019 op=3 SHALL produce out=0x00000000, with out_valid asserted normally.
REQ-020 FCVT rounding mode SHALL be fixed RNE; the fcsr frm field is not an input to this block.

Reset
REQ-021 While resetn=0, out SHALL be 0x00000000 and out_valid SHALL be 0, asynchronously and independent of clk.
REQ-022 A request sampled in the same edge that resetn deasserts, or in flight when reset asserts, SHALL be discarded.
REQ-023 The first valid result after reset SHALL appear one cycle after the first sampled in_valid=1.

Configuration
REQ-024 With macro FCLASS_CVT_NX_FLAG_EN defined, the block SHALL add an output nx (1 bit, registered with out, reset 0).
- nx = 1 when an FCVT result was rounded (guard or sticky nonzero).
- nx = 0 for FCLASS, op=3, and exact conversions.
REQ-025 Without FCLASS_CVT_NX_FLAG_EN, the nx port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 The bench SHALL check FCLASS: rs1 = 0xFF800000 / 0x80000000 / 0x00000001 / 0x7F800001 / 0x7FC00000 -> out = 0x001 / 0x008 / 0x020 / 0x100 / 0x200.
REQ-027 The bench SHALL check FCVT.S.W: rs1 = 0x00000001 / 0xFFFFFFFF / 0x80000000 / 0x00000000 -> out = 0x3F800000 / 0xBF800000 / 0xCF000000 / 0x00000000.
REQ-028 The bench SHALL check RNE:
- FCVT.S.W rs1 = 16777217 -> 0x4B800000 (tie to even; nx = 1 if enabled).
- FCVT.S.W rs1 = 16777219 -> 0x4B800002.
REQ-029 The bench SHALL check FCVT.S.WU: rs1 = 0xFFFFFFFF -> 0x4F800000; rs1 = 0x80000000 -> 0x4F000000.
REQ-030 The bench SHALL check back-to-back requests on consecutive cycles: each result appears exactly 1 cycle later, with out_valid held high.
REQ-031 The bench SHALL check reset: assert resetn=0 mid-stream -> out = 0 and out_valid = 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/fclass_cvt_unit_if.sv
// Request/result bundle for fclass_cvt_unit. The nx flag is present only
// when FCLASS_CVT_NX_FLAG_EN is defined.
interface fclass_cvt_unit_if #(
  parameter int FLEN = 32
);
  logic            in_valid;
  logic [1:0]      op;
  logic [FLEN-1:0] rs1;
  logic [FLEN-1:0] rs2;
  logic [FLEN-1:0] out;
  logic            out_valid;
`ifdef FCLASS_CVT_NX_FLAG_EN
  logic            nx;
`endif

  // in_valid is a one-cycle request with no backpressure; out_valid pulses
  // for each cycle in which out carries a fresh result.
`ifdef FCLASS_CVT_NX_FLAG_EN
  modport master (output in_valid, op, rs1, rs2, input out, out_valid, nx);
  modport slave  (input in_valid, op, rs1, rs2, output out, out_valid, nx);
`else
  modport master (output in_valid, op, rs1, rs2, input out, out_valid);
  modport slave  (input in_valid, op, rs1, rs2, output out, out_valid);
`endif
endinterface

// File: rtl/fclass_cvt_unit.sv
// Single-cycle FCLASS.S / FCVT.S.W / FCVT.S.WU unit with registered result.
// Optional inexact flag output enabled by macro FCLASS_CVT_NX_FLAG_EN.
module fclass_cvt_unit #(
  parameter int FLEN = 32
) (
  input  logic              clk,
  input  logic              resetn,
  fclass_cvt_unit_if.slave  bus
);

  localparam logic [1:0] OP_FCLASS = 2'd0;
  localparam logic [1:0] OP_CVT_W  = 2'd1;
  localparam logic [1:0] OP_CVT_WU = 2'd2;

  logic            arm_q, arm_d;
  logic [FLEN-1:0] out_q, out_d;
  logic            out_valid_q, out_valid_d;
`ifdef FCLASS_CVT_NX_FLAG_EN
  logic            nx_q, nx_d;
  logic            inexact;
`endif

  logic            unused_rs2;
  assign unused_rs2 = ^bus.rs2;

  // ---------------- FCLASS ----------------
  logic [7:0]  cls_exp;
  logic [22:0] cls_frac;
  logic        cls_sign;
  logic [9:0]  cls_res;

  always_comb begin
    cls_sign = bus.rs1[31];
    cls_exp  = bus.rs1[30:23];
    cls_frac = bus.rs1[22:0];
    cls_res  = 10'd0;
    if (cls_exp == 8'hFF) begin
      if (cls_frac == 23'd0)  cls_res[cls_sign ? 0 : 7] = 1'b1;
      else if (cls_frac[22])  cls_res[9] = 1'b1;
      else                    cls_res[8] = 1'b1;
    end else if (cls_exp == 8'h00) begin
      if (cls_frac == 23'd0)  cls_res[cls_sign ? 3 : 4] = 1'b1;
      else                    cls_res[cls_sign ? 2 : 5] = 1'b1;
    end else begin
      cls_res[cls_sign ? 1 : 6] = 1'b1;
    end
  end

  // ---------------- integer -> binary32 ----------------
  logic        cvt_neg;
  logic [31:0] mag;
  logic [4:0]  msb_idx;
  logic [4:0]  norm_shift;
  logic [31:0] norm;
  logic [23:0] sig;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [24:0] sig_rnd;
  logic        carry;
  logic [7:0]  exp_res;
  logic [22:0] mant_res;
  logic [31:0] cvt_res;

  always_comb begin
    cvt_neg = (bus.op == OP_CVT_W) && bus.rs1[31];
    // Two's-complement negate of 0x80000000 yields 0x80000000, the correct
    // unsigned magnitude 2^31.
    mag = cvt_neg ? (~bus.rs1 + 32'd1) : bus.rs1;

    msb_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb_idx = 5'(i);
    end
    norm_shift = 5'd31 - msb_idx;
    norm       = mag << norm_shift;

    sig      = norm[31:8];
    guard    = norm[7];
    sticky   = |norm[6:0];
    round_up = guard & (sticky | sig[0]);
    sig_rnd  = {1'b0, sig} + {24'd0, round_up};
    carry    = sig_rnd[24];

    exp_res  = 8'd127 + {3'd0, msb_idx} + {7'd0, carry};
    mant_res = carry ? sig_rnd[23:1] : sig_rnd[22:0];

    if (mag == 32'd0) cvt_res = 32'd0;
    else              cvt_res = {cvt_neg, exp_res, mant_res};
  end

`ifdef FCLASS_CVT_NX_FLAG_EN
  assign inexact = (mag != 32'd0) && (guard | sticky);
`endif

  // ---------------- result register ----------------
  always_comb begin
    // arm_q stays low for the first edge after reset release so a request
    // coincident with deassertion is never captured.
    arm_d       = 1'b1;
    out_d       = out_q;
    out_valid_d = 1'b0;
`ifdef FCLASS_CVT_NX_FLAG_EN
    nx_d        = nx_q;
`endif
    if (arm_q && bus.in_valid) begin
      out_valid_d = 1'b1;
      unique case (bus.op)
        OP_FCLASS: out_d = {22'd0, cls_res};
        OP_CVT_W,
        OP_CVT_WU: out_d = cvt_res;
        default:   out_d = '0;
      endcase
`ifdef FCLASS_CVT_NX_FLAG_EN
      nx_d = ((bus.op == OP_CVT_W) || (bus.op == OP_CVT_WU)) && inexact;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arm_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef FCLASS_CVT_NX_FLAG_EN
      nx_q        <= 1'b0;
`endif
    end else begin
      arm_q       <= arm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef FCLASS_CVT_NX_FLAG_EN
      nx_q        <= nx_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
`ifdef FCLASS_CVT_NX_FLAG_EN
  assign bus.nx        = nx_q;
`endif

endmodule

// File: tb/tb_fclass_cvt_unit.sv
// Self-checking bench for fclass_cvt_unit: directed vectors, random traffic
// against an arithmetic reference model, back-to-back and mid-stream reset.
module tb_fclass_cvt_unit;

  logic clk;
  logic resetn;

  fclass_cvt_unit_if #(.FLEN(32)) bus ();

  fclass_cvt_unit #(.FLEN(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] last_out;
  logic        mon_en;
  logic        mon_v;
  logic [32:0] mon_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_fclass(input logic [31:0] a);
    int idx;
    logic s;
    logic [7:0] e;
    logic [22:0] f;
    s = a[31]; e = a[30:23]; f = a[22:0];
    if (e == 8'hFF) begin
      if (f == 0)     idx = s ? 0 : 7;
      else if (f[22]) idx = 9;
      else            idx = 8;
    end else if (e == 8'h00) begin
      if (f == 0) idx = s ? 3 : 4;
      else        idx = s ? 2 : 5;
    end else begin
      idx = s ? 1 : 6;
    end
    return 32'd1 << idx;
  endfunction

  // Returns {nx, result}: exact quotient/remainder rounding on a 64-bit value.
  function automatic logic [32:0] ref_cvt(input logic [31:0] a, input bit is_signed);
    longint m, q, rem, half;
    int e, sh;
    bit neg;
    logic [7:0] be;
    logic [22:0] mt;
    m = is_signed ? longint'($signed(a)) : longint'({32'd0, a});
    neg = (m < 0);
    if (neg) m = -m;
    if (m == 0) return 33'd0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    rem = 0;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    be = 8'(127 + e);
    mt = q[22:0];
    return {(rem != 0), neg, be, mt};
  endfunction

  function automatic logic [32:0] ref_model(input logic [1:0] op, input logic [31:0] a);
    case (op)
      2'd0:    return {1'b0, ref_fclass(a)};
      2'd1:    return ref_cvt(a, 1'b1);
      2'd2:    return ref_cvt(a, 1'b0);
      default: return 33'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [32:0] exp);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.rs1      = a;
    bus.rs2      = $urandom;
    exp_q.push_back(exp);
  endtask

  task automatic drive_idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op       = 2'($urandom_range(0, 3));
    bus.rs1      = $urandom;
    bus.rs2      = $urandom;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    if (mon_en) begin
      mon_v = bus.in_valid;
      #1;
      check_eq("out_valid", 32'(bus.out_valid), 32'(mon_v));
      if (mon_v) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("out", bus.out, mon_e[31:0]);
`ifdef FCLASS_CVT_NX_FLAG_EN
          check_eq("nx", 32'(bus.nx), 32'(mon_e[32]));
`endif
          last_out = mon_e[31:0];
        end
      end else begin
        check_eq("out_hold", bus.out, last_out);
      end
    end
  end

  // ---------------- directed vectors ----------------
  localparam int N_DIR = 18;
  logic [1:0]  dir_op  [N_DIR] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                   2'd1, 2'd1, 2'd1, 2'd1,
                                   2'd1, 2'd1,
                                   2'd2, 2'd2,
                                   2'd3, 2'd0, 2'd0, 2'd2, 2'd1};
  logic [31:0] dir_rs1 [N_DIR] = '{32'hFF800000, 32'h80000000, 32'h00000001, 32'h7F800001, 32'h7FC00000,
                                   32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h00000000,
                                   32'd16777217, 32'd16777219,
                                   32'hFFFFFFFF, 32'h80000000,
                                   32'h12345678, 32'h3F800000, 32'hFFC00001, 32'h00000000, 32'h7FFFFFFF};
  logic [31:0] dir_out [N_DIR] = '{32'h001, 32'h008, 32'h020, 32'h100, 32'h200,
                                   32'h3F800000, 32'hBF800000, 32'hCF000000, 32'h00000000,
                                   32'h4B800000, 32'h4B800002,
                                   32'h4F800000, 32'h4F000000,
                                   32'h00000000, 32'h040, 32'h200, 32'h00000000, 32'h4F000000};
  logic        dir_nx  [N_DIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b1,
                                   1'b1, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [31:0] specials [8] = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                32'h01000001, 32'h00FFFFFF, 32'h7F800000, 32'h807FFFFF};

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a;
    mon_en       = 1'b0;
    last_out     = 32'd0;
    resetn       = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = 2'd0;
    bus.rs1      = 32'd0;
    bus.rs2      = 32'd0;

    #1;
    check_eq("rst_out", bus.out, 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef FCLASS_CVT_NX_FLAG_EN
    check_eq("rst_nx", 32'(bus.nx), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;
    drive_idle();
    drive_idle();
    mon_en = 1'b1;

    // directed, back-to-back on consecutive cycles
    for (int i = 0; i < N_DIR; i++) drive_req(dir_op[i], dir_rs1[i], {dir_nx[i], dir_out[i]});
    drive_idle();
    drive_idle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        r_op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       r_a = specials[$urandom_range(0, 7)];
          1:       r_a = 32'($urandom_range(0, 70000000));
          2:       r_a = 32'd1 << $urandom_range(0, 31);
          default: r_a = $urandom;
        endcase
        drive_req(r_op, r_a, ref_model(r_op, r_a));
      end else begin
        drive_idle();
      end
    end

    // mid-stream reset with a request in flight
    drive_req(2'd1, 32'd5, ref_model(2'd1, 32'd5));
    @(negedge clk);
    mon_en       = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = 2'd2;
    bus.rs1      = 32'd1234567;
    #5;
    check_eq("pre_rst_out", bus.out, ref_model(2'd1, 32'd5) & 33'hFFFFFFFF);
    #1;
    resetn = 1'b0;
    #1;
    check_eq("async_rst_out", bus.out, 32'd0);
    check_eq("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef FCLASS_CVT_NX_FLAG_EN
    check_eq("async_rst_nx", 32'(bus.nx), 32'd0);
`endif
    @(posedge clk);
    #1;
    check_eq("in_rst_out", bus.out, 32'd0);
    check_eq("in_rst_out_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    last_out = 32'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3 resetn = 1'b1;
    drive_idle();
    drive_idle();
    mon_en = 1'b1;

    drive_req(2'd1, 32'hFFFFFFFF, {1'b0, 32'hBF800000});
    drive_req(2'd2, 32'd16777219, ref_model(2'd2, 32'd16777219));
    drive_req(2'd0, 32'h00000001, {1'b0, 32'h020});
    drive_idle();
    drive_idle();
    @(negedge clk);
    mon_en = 1'b0;
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
